// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: active-area size, coordinate width, state and
// direction encodings, and the single-axis bounce step used by motion controllers.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 800;
  localparam int VGA_V_ACTIVE = 600;
  localparam int COORD_W      = 11;
  localparam int SUM_W        = COORD_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  typedef struct packed {
    logic [COORD_W-1:0] pos;
    dir_e               dir;
    logic               hit;
  } axis_t;

  // One update of one axis; the extra sum bit keeps pos+step from wrapping.
  function automatic axis_t axis_step(input logic [COORD_W-1:0] pos,
                                      input dir_e               dir,
                                      input logic [SUM_W-1:0]   step,
                                      input logic [SUM_W-1:0]   lim);
    axis_t            r;
    logic [SUM_W-1:0] pos_w;
    pos_w = {1'b0, pos};
    r.pos = pos;
    r.dir = dir;
    r.hit = 1'b0;
    if (dir == DIR_POS) begin
      if (pos_w + step >= lim) begin
        r.pos = COORD_W'(lim);
        r.dir = DIR_NEG;
        r.hit = 1'b1;
      end else begin
        r.pos = COORD_W'(pos_w + step);
      end
    end else begin
      if (pos_w <= step) begin
        r.pos = '0;
        r.dir = DIR_POS;
        r.hit = 1'b1;
      end else begin
        r.pos = COORD_W'(pos_w - step);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_frame_edge.sv
// Rising-edge detector for vertical blanking: fe is high for the single cycle
// where vblnk_in is high but was low on the previous pclk.
module vga_frame_edge (
  input  logic pclk,
  input  logic rst,
  input  logic vblnk_in,
  output logic fe
);

  logic vblnk_d_q;
  logic vblnk_d_d;

  always_comb vblnk_d_d = vblnk_in;

  // NOTE: reset is synchronous here (only sampled on pclk), and state flops use <=.
  always_ff @(posedge pclk) begin
    if (rst) vblnk_d_q <= 1'b0;
    else     vblnk_d_q <= vblnk_d_d;
  end

  assign fe = vblnk_in & ~vblnk_d_q;

endmodule

// File: rtl/vga_rect_motion_ctl.sv
// Per-frame bouncing-rectangle position controller; positions change only on the
// rising edge of vblnk_in. Optional frame divider under macro VGA_RECT_FRAME_DIV_EN.
module vga_rect_motion_ctl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int RECT_W   = 48,
  parameter int RECT_H   = 64,
  parameter int STEP_X   = 2,
  parameter int STEP_Y   = 1,
  parameter int X0       = 100,
  parameter int Y0       = 100
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               vblnk_in,
  input  logic               start,
  input  logic               stop,
`ifdef VGA_RECT_FRAME_DIV_EN
  input  logic [3:0]         frame_div,
`endif
  output logic [COORD_W-1:0] xpos,
  output logic [COORD_W-1:0] ypos,
  output logic               busy,
  output logic               frame_tick,
  output logic               bounce
);

  localparam int XMAX = H_ACTIVE - RECT_W;
  localparam int YMAX = V_ACTIVE - RECT_H;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  dir_e               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic               busy_q, busy_d;
  logic               tick_q, tick_d;
  logic               bounce_q, bounce_d;
  logic               fe;
  logic               move;
  axis_t              nx, ny;
`ifdef VGA_RECT_FRAME_DIV_EN
  logic [3:0]         cnt_q, cnt_d;
`endif

  vga_frame_edge u_frame_edge (
    .pclk     (pclk),
    .rst      (rst),
    .vblnk_in (vblnk_in),
    .fe       (fe)
  );

  assign nx = axis_step(x_q, dir_x_q, SUM_W'(STEP_X), SUM_W'(XMAX));
  assign ny = axis_step(y_q, dir_y_q, SUM_W'(STEP_Y), SUM_W'(YMAX));

  // NOTE: every variable gets a default first so no path through this block infers a latch.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    tick_d   = 1'b0;
    bounce_d = 1'b0;
    move     = 1'b0;
`ifdef VGA_RECT_FRAME_DIV_EN
    cnt_d    = cnt_q;
`endif
    if (stop) begin
      // stop outranks start and a coincident frame edge in either state
      state_d = IDLE;
      x_d     = COORD_W'(X0);
      y_d     = COORD_W'(Y0);
      dir_x_d = DIR_POS;
      dir_y_d = DIR_POS;
`ifdef VGA_RECT_FRAME_DIV_EN
      cnt_d   = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
`ifdef VGA_RECT_FRAME_DIV_EN
            cnt_d   = '0;
`endif
          end
        end
        RUN: begin
          if (fe) begin
`ifdef VGA_RECT_FRAME_DIV_EN
            if (cnt_q == frame_div) begin
              move  = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
`else
            move = 1'b1;
`endif
          end
        end
      endcase
    end
    if (move) begin
      x_d      = nx.pos;
      y_d      = ny.pos;
      dir_x_d  = nx.dir;
      dir_y_d  = ny.dir;
      tick_d   = 1'b1;
      bounce_d = nx.hit | ny.hit;
    end
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= COORD_W'(X0);
      y_q      <= COORD_W'(Y0);
      dir_x_q  <= DIR_POS;
      dir_y_q  <= DIR_POS;
      busy_q   <= 1'b0;
      tick_q   <= 1'b0;
      bounce_q <= 1'b0;
`ifdef VGA_RECT_FRAME_DIV_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      busy_q   <= busy_d;
      tick_q   <= tick_d;
      bounce_q <= bounce_d;
`ifdef VGA_RECT_FRAME_DIV_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign xpos       = x_q;
  assign ypos       = y_q;
  assign busy       = busy_q;
  assign frame_tick = tick_q;
  assign bounce     = bounce_q;

endmodule

// File: tb/tb_vga_rect_motion_ctl.sv
// Directed bench for vga_rect_motion_ctl: default instance plus a right-wall
// instance (X0=750) and a tiny-area corner instance (XMAX=2, YMAX=1, X0=1, Y0=0).
module tb_vga_rect_motion_ctl;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        vblnk_in = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
`ifdef VGA_RECT_FRAME_DIV_EN
  logic [3:0]  frame_div = 4'd0;
`endif

  logic [10:0] d_x, d_y, r_x, r_y, c_x, c_y;
  logic        d_busy, d_tick, d_bounce;
  logic        r_busy, r_tick, r_bounce;
  logic        c_busy, c_tick, c_bounce;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 pclk = ~pclk;

  vga_rect_motion_ctl u_dut (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in), .start(start), .stop(stop),
`ifdef VGA_RECT_FRAME_DIV_EN
    .frame_div(frame_div),
`endif
    .xpos(d_x), .ypos(d_y), .busy(d_busy), .frame_tick(d_tick), .bounce(d_bounce)
  );

  vga_rect_motion_ctl #(.X0(750)) u_right (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in), .start(start), .stop(stop),
`ifdef VGA_RECT_FRAME_DIV_EN
    .frame_div(frame_div),
`endif
    .xpos(r_x), .ypos(r_y), .busy(r_busy), .frame_tick(r_tick), .bounce(r_bounce)
  );

  vga_rect_motion_ctl #(.H_ACTIVE(50), .V_ACTIVE(65), .X0(1), .Y0(0)) u_corner (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in), .start(start), .stop(stop),
`ifdef VGA_RECT_FRAME_DIV_EN
    .frame_div(frame_div),
`endif
    .xpos(c_x), .ypos(c_y), .busy(c_busy), .frame_tick(c_tick), .bounce(c_bounce)
  );

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge pclk);
  endtask

  task automatic apply_reset();
    @(negedge pclk);
    rst = 1'b1; start = 1'b0; stop = 1'b0; vblnk_in = 1'b0;
    cycles(3);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
  endtask

  // Raise vblank and step to the sample point one pclk later.
  task automatic vblank_rise();
    vblnk_in = 1'b1;
    @(negedge pclk);
  endtask

  // Hold vblank for the rest of the blank period, counting any further ticks.
  task automatic vblank_finish(input int hold, output int extra);
    extra = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge pclk);
      if (d_tick) extra++;
    end
    vblnk_in = 1'b0;
    cycles(6);
  endtask

  task automatic test_reset();
    int ticks;
    apply_reset();
    if ({d_x, d_y} !== {11'd100, 11'd100}) begin
      $display("FAIL reset_pos: got x=%0d y=%0d want x=100 y=100", d_x, d_y); n_bad++;
    end
    n_cmp++;
    if ({d_busy, d_tick, d_bounce} !== 3'b000) begin
      $display("FAIL reset_flags: got busy/tick/bounce=%b want 000", {d_busy, d_tick, d_bounce}); n_bad++;
    end
    n_cmp++;
    ticks = 0;
    for (int f = 0; f < 4; f++) begin
      vblnk_in = 1'b1;
      for (int i = 0; i < 10; i++) begin @(negedge pclk); if (d_tick) ticks++; end
      vblnk_in = 1'b0;
      for (int i = 0; i < 10; i++) begin @(negedge pclk); if (d_tick) ticks++; end
    end
    if (ticks !== 0 || d_x !== 11'd100 || d_y !== 11'd100 || d_busy !== 1'b0) begin
      $display("FAIL idle_frames: got ticks=%0d x=%0d y=%0d busy=%b want 0 100 100 0",
               ticks, d_x, d_y, d_busy); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_basic_motion();
    int extra;
    apply_reset();
    pulse_start();
    if (d_busy !== 1'b1) begin
      $display("FAIL start_busy: got %b want 1", d_busy); n_bad++;
    end
    n_cmp++;
    for (int f = 1; f <= 3; f++) begin
      vblnk_in = 1'b1;
      #1;
      if (d_tick !== 1'b0 || d_x !== 11'(100 + 2 * (f - 1))) begin
        $display("FAIL early_update f%0d: got tick=%b x=%0d want 0 %0d", f, d_tick, d_x, 100 + 2 * (f - 1)); n_bad++;
      end
      n_cmp++;
      @(negedge pclk);
      if (d_x !== 11'(100 + 2 * f) || d_y !== 11'(100 + f) || d_tick !== 1'b1 || d_bounce !== 1'b0) begin
        $display("FAIL move f%0d: got x=%0d y=%0d tick=%b bounce=%b want %0d %0d 1 0",
                 f, d_x, d_y, d_tick, d_bounce, 100 + 2 * f, 100 + f); n_bad++;
      end
      n_cmp++;
      vblank_finish(28, extra);
      if (extra !== 0 || d_x !== 11'(100 + 2 * f)) begin
        $display("FAIL hold f%0d: got extra_ticks=%0d x=%0d want 0 %0d", f, extra, d_x, 100 + 2 * f); n_bad++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_right_bounce();
    int extra;
    apply_reset();
    pulse_start();
    vblank_rise();
    if (r_x !== 11'd752 || r_bounce !== 1'b1 || r_tick !== 1'b1) begin
      $display("FAIL right_hit: got x=%0d bounce=%b tick=%b want 752 1 1", r_x, r_bounce, r_tick); n_bad++;
    end
    n_cmp++;
    vblank_finish(4, extra);
    vblank_rise();
    if (r_x !== 11'd750 || r_bounce !== 1'b0 || r_tick !== 1'b1) begin
      $display("FAIL right_return: got x=%0d bounce=%b tick=%b want 750 0 1", r_x, r_bounce, r_tick); n_bad++;
    end
    n_cmp++;
    vblank_finish(4, extra);
  endtask

  task automatic test_corner();
    int extra;
    apply_reset();
    pulse_start();
    vblank_rise();
    if (c_x !== 11'd2 || c_y !== 11'd1 || c_bounce !== 1'b1) begin
      $display("FAIL corner_far: got x=%0d y=%0d bounce=%b want 2 1 1", c_x, c_y, c_bounce); n_bad++;
    end
    n_cmp++;
    vblank_finish(4, extra);
    vblank_rise();
    if (c_x !== 11'd0 || c_y !== 11'd0 || c_bounce !== 1'b1 || c_tick !== 1'b1) begin
      $display("FAIL corner_origin: got x=%0d y=%0d bounce=%b tick=%b want 0 0 1 1",
               c_x, c_y, c_bounce, c_tick); n_bad++;
    end
    n_cmp++;
    @(negedge pclk);
    if (c_bounce !== 1'b0 || c_tick !== 1'b0) begin
      $display("FAIL corner_single_pulse: got bounce=%b tick=%b want 0 0", c_bounce, c_tick); n_bad++;
    end
    n_cmp++;
    vblank_finish(3, extra);
    vblank_rise();
    if (c_x !== 11'd2 || c_y !== 11'd1) begin
      $display("FAIL corner_rebound: got x=%0d y=%0d want 2 1", c_x, c_y); n_bad++;
    end
    n_cmp++;
    vblank_finish(3, extra);
  endtask

  task automatic test_conflicts();
    int extra;
    apply_reset();
    start = 1'b1; stop = 1'b1;
    @(negedge pclk);
    start = 1'b0; stop = 1'b0;
    if (d_busy !== 1'b0 || d_x !== 11'd100 || d_y !== 11'd100) begin
      $display("FAIL start_stop: got busy=%b x=%0d y=%0d want 0 100 100", d_busy, d_x, d_y); n_bad++;
    end
    n_cmp++;
    // start coincident with a frame edge in IDLE: enter RUN without moving
    start = 1'b1; vblnk_in = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    if (d_busy !== 1'b1 || d_x !== 11'd100 || d_tick !== 1'b0) begin
      $display("FAIL start_with_fe: got busy=%b x=%0d tick=%b want 1 100 0", d_busy, d_x, d_tick); n_bad++;
    end
    n_cmp++;
    vblank_finish(4, extra);
    vblank_rise();
    if (d_x !== 11'd102 || d_y !== 11'd101) begin
      $display("FAIL first_move_after_start: got x=%0d y=%0d want 102 101", d_x, d_y); n_bad++;
    end
    n_cmp++;
    vblank_finish(4, extra);
    stop = 1'b1; vblnk_in = 1'b1;
    @(negedge pclk);
    stop = 1'b0;
    if (d_x !== 11'd100 || d_y !== 11'd100 || d_tick !== 1'b0 || d_busy !== 1'b0) begin
      $display("FAIL stop_with_fe: got x=%0d y=%0d tick=%b busy=%b want 100 100 0 0",
               d_x, d_y, d_tick, d_busy); n_bad++;
    end
    n_cmp++;
    vblank_finish(4, extra);
    pulse_start();
    vblank_rise();
    vblank_finish(4, extra);
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    if (d_x !== 11'd100 || d_y !== 11'd100 || d_busy !== 1'b0 || d_tick !== 1'b0) begin
      $display("FAIL mid_run_reset: got x=%0d y=%0d busy=%b tick=%b want 100 100 0 0",
               d_x, d_y, d_busy, d_tick); n_bad++;
    end
    n_cmp++;
    vblank_rise();
    vblank_finish(4, extra);
    if (d_x !== 11'd100 || d_busy !== 1'b0) begin
      $display("FAIL reset_needs_start: got x=%0d busy=%b want 100 0", d_x, d_busy); n_bad++;
    end
    n_cmp++;
  endtask

`ifdef VGA_RECT_FRAME_DIV_EN
  task automatic test_frame_div();
    int moves;
    int extra;
    frame_div = 4'd2;
    apply_reset();
    pulse_start();
    moves = 0;
    for (int f = 0; f < 9; f++) begin
      vblank_rise();
      if (d_tick) moves++;
      vblank_finish(4, extra);
      moves += extra;
    end
    if (moves !== 3 || d_x !== 11'd106 || d_y !== 11'd103) begin
      $display("FAIL frame_div: got moves=%0d x=%0d y=%0d want 3 106 103", moves, d_x, d_y); n_bad++;
    end
    n_cmp++;
    frame_div = 4'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_motion();
    test_right_bounce();
    test_corner();
    test_conflicts();
`ifdef VGA_RECT_FRAME_DIV_EN
    test_frame_div();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
